pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register, the successor to the fixed-format ID/EX latch. It moves an opaque payload (default: ID/EX bundle of aluop, alusel, reg1, reg2, wd, wreg) between two pipeline stages using a valid/ready handshake instead of a global stall vector. A one-entry skid buffer keeps `in_ready` registered, so stall paths are cut at every stage. It adds flush, explicit bubble insertion and saturating stall/bubble performance counters, and is instantiated once per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- `DATA_W`, 81 — payload width in bits (ID/EX default: 8+3+32+32+5+1).
- `BUBBLE_DATA`, 0 — payload presented whenever `out_valid`=0; for ID/EX this is the NOP encoding (NOP op, NOP sel, zero words, NOP reg addr, write disabled).
- `CNT_W`, 16 — performance counter width.
- `clk` in 1 — single clock; all state updates on rising edge.
- `rst` in 1 — reset is synchronous and active-high.
- `flush` in 1 — discard all held entries this cycle.
- `in_valid` in 1 — upstream has a payload.
- `in_ready` out 1 — stage can accept; registered.
- `in_data` in DATA_W — upstream payload.
- `out_valid` out 1 — `out_data` holds a real instruction.
- `out_ready` in 1 — downstream accepts this cycle.
- `out_data` out DATA_W — payload; equals `BUBBLE_DATA` when `out_valid`=0.
- `stall_cnt` out CNT_W — cycles with `out_valid`=1 and `out_ready`=0; saturating.
- `bubble_cnt` out CNT_W — cycles with `out_valid`=0 and `out_ready`=1; saturating.

## Operation
- State: main register (`m_valid`, `m_data`) drives the outputs; skid register (`s_valid`, `s_data`) holds the overflow entry.
- `in_ready` = !`s_valid`. An upstream transfer happens when `in_valid` & `in_ready`. A downstream transfer happens when `out_valid` & `out_ready`.
- Per-cycle update, with flush absent:
  - Main empty, or main transferring: main loads skid if `s_valid`, otherwise loads `in_data` if an upstream transfer occurs, otherwise goes invalid.
  - Skid absorbs `in_data` when an upstream transfer occurs while main is full and not transferring.
  - Skid clears when its entry moves to main. If main loads from skid and an upstream transfer occurs in the same cycle, that cannot happen: `in_ready`=0 whenever skid is full.
- Whenever `m_valid`=0, `m_data` is forced to `BUBBLE_DATA`. Downstream logic that ignores valid therefore sees a NOP, matching legacy bubble semantics.
- `flush`=1: `m_valid`, `s_valid` ← 0 and `m_data` ← `BUBBLE_DATA` next cycle. Input in the same cycle is dropped even if `in_valid`=1. Counters are not reset.
- Counters increment by 1 per qualifying cycle and hold at 2^CNT_W−1. They are cleared only by `rst`.
- Ordering is strict FIFO: no entry is ever duplicated or dropped except by flush.

## Timing
- Reset (`rst`=1 at an edge): `out_valid`=0, `out_data`=`BUBBLE_DATA`, `in_ready`=1, skid empty, `stall_cnt`=`bubble_cnt`=0. Reset overrides flush and all inputs.
- Latency: an entry accepted at edge N appears on `out_data` after edge N, i.e. 1 cycle, when main is free.
- Throughput: 1 entry/cycle with `out_ready` held at 1.
- Backpressure: `in_ready` falls one cycle after the first refused downstream cycle, and only if a second entry arrived. Maximum occupancy is 2.
- `in_ready` and all outputs are register outputs. No combinational path runs from `out_ready` to `in_ready`.
- Simultaneous flush and `out_ready`: the downstream transfer of the current main entry is counted as taken; the next state is still empty.

## Structure
- Shared package `pipe_pkg`: ID/EX payload struct/field offsets, `ID_EX_W`=81, and NOP bubble constants built from the existing NOP op/sel/reg-addr defines.
- Natural sub-module: `sat_counter` (parameter W; inputs `inc` and `rst`), instantiated twice.
- The skid/main datapath stays inline in `pipe_stage_reg`.

## Test plan
- Reset, then `in_valid`=1 with data 0x1 and `out_ready`=1 → `out_valid`=1 and `out_data`=0x1 one cycle later; stream 0x1..0x10 emerges in order, one per cycle.
- Hold `out_ready`=0 with `in_valid`=1 pushing 0xA, 0xB → `out_data`=0xA and skid holds 0xB; `in_ready`=0 from the 2nd cycle on. Release → 0xA, then 0xB, then `in_ready`=1.
- Occupancy 2 (0xA, 0xB), assert `flush` with `in_valid`=1 carrying 0xC → next cycle `out_valid`=0, `out_data`=`BUBBLE_DATA`, `in_ready`=1, and 0xC never emerges.
- `in_valid`=0 with `out_ready`=1 for 5 cycles → `bubble_cnt`=5; then a held entry with `out_ready`=0 for 3 cycles → `stall_cnt`=3.
- CNT_W=4: 20 stall cycles → `stall_cnt` sticks at 15.
- Assert `rst` mid-backpressure (occupancy 2) → next cycle matches the reset values above and the counters read 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ID/EX payload layout and the NOP bubble
// presented by every stage register while it holds no instruction.
package pipe_pkg;

    localparam int ALUOP_W    = 8;
    localparam int ALUSEL_W   = 3;
    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam int ID_EX_W = ALUOP_W + ALUSEL_W + 2 * WORD_W + REG_ADDR_W + 1;

    // LSB offsets of each field inside the packed ID/EX word
    localparam int WREG_LSB   = 0;
    localparam int WD_LSB     = WREG_LSB + 1;
    localparam int REG2_LSB   = WD_LSB + REG_ADDR_W;
    localparam int REG1_LSB   = REG2_LSB + WORD_W;
    localparam int ALUSEL_LSB = REG1_LSB + WORD_W;
    localparam int ALUOP_LSB  = ALUSEL_LSB + ALUSEL_W;

    localparam logic [ALUOP_W-1:0]    EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [ALUSEL_W-1:0]   EXE_RES_NOP  = 3'b000;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = 5'b00000;

    typedef struct packed {
        logic [ALUOP_W-1:0]    aluop;
        logic [ALUSEL_W-1:0]   alusel;
        logic [WORD_W-1:0]     reg1;
        logic [WORD_W-1:0]     reg2;
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
    } id_ex_t;

    localparam id_ex_t ID_EX_NOP = '{
        aluop:  EXE_NOP_OP,
        alusel: EXE_RES_NOP,
        reg1:   '0,
        reg2:   '0,
        wd:     NOP_REG_ADDR,
        wreg:   1'b0
    };

    localparam logic [ID_EX_W-1:0] ID_EX_BUBBLE = ID_EX_NOP;

    // Performance counter slots inside each stage register
    localparam int PERF_STALL   = 0;
    localparam int PERF_BUBBLE  = 1;
    localparam int NUM_PERF_CNT = 2;

    function automatic logic [ID_EX_W-1:0] pack_id_ex(input id_ex_t fields);
        return fields;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter: +1 per cycle with inc high, sticks at all-ones
// until the synchronous reset clears it.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (inc && (count_reg != {W{1'b1}})) begin
            count_next = count_reg + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with a one-entry skid buffer so that
// in_ready comes straight from a flop; adds flush and stall/bubble counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = ID_EX_W,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(ID_EX_BUBBLE),
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              m_valid_reg;
    logic              m_valid_next;
    logic [DATA_W-1:0] m_data_reg;
    logic [DATA_W-1:0] m_data_next;
    logic              s_valid_reg;
    logic              s_valid_next;
    logic [DATA_W-1:0] s_data_reg;
    logic [DATA_W-1:0] s_data_next;

    logic up_xfer;
    logic down_xfer;
    logic main_free;

    // in_ready depends only on the skid flop, never on out_ready
    assign up_xfer   = in_valid & ~s_valid_reg;
    assign down_xfer = m_valid_reg & out_ready;
    assign main_free = ~m_valid_reg | down_xfer;

    always_comb begin
        m_valid_next = m_valid_reg;
        m_data_next  = m_data_reg;
        s_valid_next = s_valid_reg;
        s_data_next  = s_data_reg;

        if (flush) begin
            m_valid_next = 1'b0;
            m_data_next  = BUBBLE_DATA;
            s_valid_next = 1'b0;
        end else if (main_free) begin
            if (s_valid_reg) begin
                m_valid_next = 1'b1;
                m_data_next  = s_data_reg;
                s_valid_next = 1'b0;
            end else if (up_xfer) begin
                m_valid_next = 1'b1;
                m_data_next  = in_data;
            end else begin
                m_valid_next = 1'b0;
                m_data_next  = BUBBLE_DATA;
            end
        end else if (up_xfer) begin
            // main is stalled with a free skid slot: park the newcomer
            s_valid_next = 1'b1;
            s_data_next  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_reg <= 1'b0;
            m_data_reg  <= BUBBLE_DATA;
            s_valid_reg <= 1'b0;
            s_data_reg  <= BUBBLE_DATA;
        end else begin
            m_valid_reg <= m_valid_next;
            m_data_reg  <= m_data_next;
            s_valid_reg <= s_valid_next;
            s_data_reg  <= s_data_next;
        end
    end

    assign in_ready  = ~s_valid_reg;
    assign out_valid = m_valid_reg;
    assign out_data  = m_data_reg;

    logic [NUM_PERF_CNT-1:0] cnt_inc;
    logic [CNT_W-1:0]        cnt_val [NUM_PERF_CNT];

    assign cnt_inc[PERF_STALL]  = m_valid_reg & ~out_ready;
    assign cnt_inc[PERF_BUBBLE] = ~m_valid_reg & out_ready;

    generate
        for (genvar gi = 0; gi < NUM_PERF_CNT; gi++) begin : g_perf
            sat_counter #(
                .W(CNT_W)
            ) u_cnt (
                .clk  (clk),
                .rst  (rst),
                .inc  (cnt_inc[gi]),
                .count(cnt_val[gi])
            );
        end
    endgenerate

    assign stall_cnt  = cnt_val[PERF_STALL];
    assign bubble_cnt = cnt_val[PERF_BUBBLE];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: the stimulus pushes expected payloads
// into a queue, a negedge monitor pops them as the DUT hands them downstream.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int DW = ID_EX_W;
    localparam logic [DW-1:0] BUBBLE = ID_EX_BUBBLE;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [15:0]   stall_cnt;
    logic [15:0]   bubble_cnt;

    logic       sm_flush;
    logic       sm_in_valid;
    logic       sm_in_ready;
    logic [7:0] sm_in_data;
    logic       sm_out_valid;
    logic       sm_out_ready;
    logic [7:0] sm_out_data;
    logic [3:0] sm_stall_cnt;
    logic [3:0] sm_bubble_cnt;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.DATA_W(8), .BUBBLE_DATA(8'h00), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .flush(sm_flush),
        .in_valid(sm_in_valid), .in_ready(sm_in_ready), .in_data(sm_in_data),
        .out_valid(sm_out_valid), .out_ready(sm_out_ready), .out_data(sm_out_data),
        .stall_cnt(sm_stall_cnt), .bubble_cnt(sm_bubble_cnt)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end else begin
            $display("check %s = %0h ok", name, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        exp_q.push_back(d);
    endtask

    // Scoreboard monitor: a handoff is what the DUT presents at the next edge
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out got=%0h expected=none", out_data);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    check("xfer_data", out_data, e);
                end
            end else if (!out_valid) begin
                check("bubble_data", out_data, BUBBLE);
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        sm_flush = 1'b0; sm_in_valid = 1'b0; sm_in_data = '0; sm_out_ready = 1'b0;
        step();
        step();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, BUBBLE);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_stall_cnt", stall_cnt, 16'd0);
        check("rst_bubble_cnt", bubble_cnt, 16'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // five idle cycles with downstream ready
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("bubble_cnt_5", bubble_cnt, 16'd5);

        // one entry held for three refused cycles
        out_ready = 1'b0;
        push(DW'(16'h55));
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("stall_cnt_3", stall_cnt, 16'd3);
        check("bubble_cnt_held", bubble_cnt, 16'd5);
        out_ready = 1'b1;
        step();

        // streaming 0x1..0x10, one per cycle, single-cycle latency
        push(DW'(1));
        step();
        check("lat_out_valid", out_valid, 1'b1);
        check("lat_out_data", out_data, DW'(1));
        for (int k = 2; k <= 16; k++) begin
            push(DW'(k));
            step();
            check("stream_in_ready", in_ready, 1'b1);
        end
        in_valid = 1'b0;
        step();
        step();
        check("stream_drained", exp_q.size(), 0);

        // backpressure: 0xA in main, 0xB in skid
        out_ready = 1'b0;
        push(DW'(8'hA));
        step();
        check("bp_in_ready_1", in_ready, 1'b1);
        check("bp_main_a", out_data, DW'(8'hA));
        push(DW'(8'hB));
        step();
        check("bp_in_ready_2", in_ready, 1'b0);
        in_data = DW'(8'hEE);
        step();
        check("bp_in_ready_hold", in_ready, 1'b0);
        check("bp_main_still_a", out_data, DW'(8'hA));
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_main_b", out_data, DW'(8'hB));
        check("bp_in_ready_back", in_ready, 1'b1);
        step();
        check("bp_empty", out_valid, 1'b0);

        // flush at occupancy 2 with a live input that must be dropped
        out_ready = 1'b0;
        push(DW'(8'hA));
        step();
        push(DW'(8'hB));
        step();
        check("fl_full", in_ready, 1'b0);
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = DW'(8'hC);
        exp_q.delete();
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", out_valid, 1'b0);
        check("fl_out_data", out_data, BUBBLE);
        check("fl_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // 4-bit counter saturation on the small instance
        sm_in_valid = 1'b1;
        sm_in_data = 8'h3C;
        step();
        sm_in_valid = 1'b0;
        check("sm_out_data", sm_out_data, 8'h3C);
        for (int i = 0; i < 14; i++) step();
        check("sm_stall_14", sm_stall_cnt, 4'd14);
        for (int i = 0; i < 6; i++) step();
        check("sm_stall_sat", sm_stall_cnt, 4'd15);
        check("sm_bubble_0", sm_bubble_cnt, 4'd0);

        // reset while both entries are held
        out_ready = 1'b0;
        push(DW'(8'hA));
        step();
        push(DW'(8'hB));
        step();
        in_valid = 1'b0;
        check("mr_full", in_ready, 1'b0);
        rst = 1'b1;
        flush = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        flush = 1'b0;
        check("mr_out_valid", out_valid, 1'b0);
        check("mr_out_data", out_data, BUBBLE);
        check("mr_in_ready", in_ready, 1'b1);
        check("mr_stall_cnt", stall_cnt, 16'd0);
        check("mr_bubble_cnt", bubble_cnt, 16'd0);
        check("mr_sm_stall_cnt", sm_stall_cnt, 4'd0);
        out_ready = 1'b1;
        step();
        step();
        check("final_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
